// File: rtl/instruction_fetch.sv
// instruction_fetch: ROM half-word fetch, 32-bit word assembly, prefetch FIFO with valid/ready output.
// Optional FETCH_PERF_EN adds the stall_count output (cycles with no valid instruction).
module instruction_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] rom_add,
  output logic        rom_read,
  input  logic [15:0] rom_data,
  output logic [31:0] control_word,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic [15:0] jump_addr
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] stall_count
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef enum logic {ISSUE_LO, ISSUE_HI} state_t;
  state_t      state;
  logic [14:0] fetch_pc;
  logic        epoch;
  logic [CW-1:0] occ, infl, wr_idx;
  logic [CW:0] used;
  logic        p_v, p_hi, p_ep, ret_ok, push, pop;
  logic [14:0] p_pc;
  logic [15:0] lo_hold;
  logic [31:0] cw_q [DEPTH];
  logic [14:0] pc_q [DEPTH];

  // A hi read completes an instruction already counted in flight, so only lo reads are gated by space.
  assign used         = {1'b0, occ} + {1'b0, infl};
  assign rom_read     = rst_n && !jump && (state == ISSUE_HI || used < (CW + 1)'(DEPTH));
  assign rom_add      = {fetch_pc, state == ISSUE_HI};
  assign ret_ok       = p_v && p_ep == epoch;
  assign push         = ret_ok && p_hi && !jump;
  assign pop          = instr_valid && instr_ready;
  assign wr_idx       = occ - CW'(pop);
  assign instr_valid  = occ != '0;
  assign control_word = cw_q[0];
  assign instr_pc     = {1'b0, pc_q[0]};

  // Issue FSM: alternate lo/hi reads, advance the pc after the hi read, redirect on jump.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ISSUE_LO;
      fetch_pc <= RESET_PC[14:0];
      epoch    <= 1'b0;
    end else if (jump) begin
      state    <= ISSUE_LO;
      fetch_pc <= jump_addr[14:0];
      epoch    <= ~epoch;
    end else if (rom_read) begin
      state    <= state == ISSUE_LO ? ISSUE_HI : ISSUE_LO;
      fetch_pc <= state == ISSUE_HI ? fetch_pc + 15'd1 : fetch_pc;
    end

  // Return tracking: tag each read with the epoch so reads issued before a jump are dropped.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_v     <= 1'b0;
      p_hi    <= 1'b0;
      p_ep    <= 1'b0;
      p_pc    <= '0;
      lo_hold <= '0;
    end else begin
      p_v     <= rom_read;
      p_hi    <= state == ISSUE_HI;
      p_ep    <= epoch;
      p_pc    <= fetch_pc;
      lo_hold <= ret_ok && !p_hi ? rom_data : lo_hold;
    end

  // Occupancy and in-flight counts; an instruction is in flight from its lo issue until its push.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      occ  <= '0;
      infl <= '0;
    end else begin
      occ  <= jump ? '0 : occ + CW'(push) - CW'(pop);
      infl <= jump ? '0 : infl + CW'(rom_read && state == ISSUE_LO) - CW'(push);
    end

  // Shift FIFO: entry 0 is the registered head; a push lands after any same-cycle pop shift.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cw_q[i] <= '0;
        pc_q[i] <= RESET_PC[14:0];
      end
    end else begin
      if (pop)
        for (int i = 0; i < DEPTH - 1; i++) begin
          cw_q[i] <= cw_q[i+1];
          pc_q[i] <= pc_q[i+1];
        end
      if (push) begin
        cw_q[wr_idx[CW-2:0]] <= {rom_data, lo_hold};
        pc_q[wr_idx[CW-2:0]] <= p_pc;
      end
    end

`ifdef FETCH_PERF_EN
  // Saturating count of cycles without a valid instruction; restarts after a redirect.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_count <= '0;
    else if (jump) stall_count <= '0;
    else if (!instr_valid && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch latency, backpressure, jump flush, wrap and reset.
module tb_instruction_fetch;
  logic        clk = 0, rst_n = 0, rom_read, instr_valid, instr_ready = 0, jump = 0;
  logic [15:0] rom_add, rom_data = 0, instr_pc, jump_addr = 0;
  logic [31:0] control_word;
  int          errors = 0, checks = 0, reads;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_count;
`endif

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .rom_add(rom_add), .rom_read(rom_read), .rom_data(rom_data),
    .control_word(control_word), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jump(jump), .jump_addr(jump_addr)
`ifdef FETCH_PERF_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return a == 16'd0 ? 16'h0018 : a == 16'd1 ? 16'h1234 : ~a;
  endfunction

  function automatic logic [31:0] exp_cw(input logic [15:0] p);
    return {rom({p[14:0], 1'b1}), rom({p[14:0], 1'b0})};
  endfunction

  always @(posedge clk) rom_data <= rom_read ? rom(rom_add) : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0; jump = 0; instr_ready = 0;
    repeat (2) step;
    check("rst_valid", instr_valid, 0);
    check("rst_cw", control_word, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_read", rom_read, 0);
    rst_n = 1;
    #1;
  endtask

  task automatic do_jump(input logic [15:0] addr);
    jump = 1; jump_addr = addr;
    #1;
    check("jump_noread", rom_read, 0);
    step;
    jump = 0;
    #1;
  endtask

  task automatic drain(input int n, input logic [15:0] start);
    logic [15:0] e;
    int got;
    e = start; got = 0; instr_ready = 1;
    for (int c = 0; c < 4 * n + 10 && got < n; c++) begin
      if (instr_valid) begin
        check("drain_pc", instr_pc, e);
        check("drain_cw", control_word, exp_cw(e));
        e = (e + 16'd1) & 16'h7FFF;
        got++;
      end
      step;
    end
    if (got < n) check("drain_timeout", got, n);
  endtask

  initial begin
    do_reset;
    instr_ready = 1;
    check("t1_read0", rom_read, 1);
    check("t1_add0", rom_add, 16'h0000);
    step;
    check("t1_add1", rom_add, 16'h0001);
    step;
    check("t1_v2", instr_valid, 0);
    step;
    check("t1_v3", instr_valid, 1);
    check("t1_cw", control_word, 32'h12340018);
    check("t1_pc", instr_pc, 16'h0000);
`ifdef FETCH_PERF_EN
    check("t1_stall", stall_count, 16'd3);
`endif
    drain(5, 16'h0000);

    do_reset;
    reads = 0;
    for (int c = 0; c < 20; c++) begin
      reads += int'(rom_read);
      step;
    end
    check("t2_reads", reads, 4);
    check("t2_idle", rom_read, 0);
    check("t2_valid", instr_valid, 1);
    check("t2_head", instr_pc, 16'h0000);
    drain(6, 16'h0000);

    do_reset;
    repeat (4) step;
    check("t3_pre_valid", instr_valid, 1);
    do_jump(16'h0040);
    check("t3_valid", instr_valid, 0);
    check("t3_add", rom_add, 16'h0080);
    check("t3_read", rom_read, 1);
`ifdef FETCH_PERF_EN
    check("t3_stall", stall_count, 16'd0);
`endif
    drain(3, 16'h0040);

    instr_ready = 0;
    do_jump(16'h7FFF);
    check("t4_a0", rom_add, 16'hFFFE);
    step;
    check("t4_a1", rom_add, 16'hFFFF);
    step;
    check("t4_a2", rom_add, 16'h0000);
    step;
    check("t4_a3", rom_add, 16'h0001);
    drain(3, 16'h7FFF);

    do_reset;
    repeat (3) step;
    rst_n = 0;
    #1;
    check("t5_read", rom_read, 0);
    check("t5_valid", instr_valid, 0);
    check("t5_pc", instr_pc, 16'h0000);
    step;
    rst_n = 1;
    #1;
    check("t5_add0", rom_add, 16'h0000);
    check("t5_read0", rom_read, 1);
    drain(3, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
